spi_byte_shifter: RTL and testbench
===================================

SPI_BYTE_SHIFTER -- requirements
Module: spi_byte_shifter

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of input synchronizer flops per SPI pin (legal 2..4).
REQ-002 SHALL have parameter BITS, default 8, meaning the SPI word length.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: CLK  in  1  system clock, all logic on posedge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 SCK  in  1  raw SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-006 MOSI  in  1  raw SPI data in, MSB first.
REQ-007 _CS  in  1  raw chip select, active low.
REQ-008 MISO  out  1  SPI data out, MSB first.
REQ-009 TxByte  in  BITS  word to transmit, sampled at each load point.
REQ-010 RxByte  out  BITS  last completed received word, held until the next completed word.
REQ-011 RxValid  out  1  one-CLK pulse on each completed word.
REQ-012 FirstByte  out  1  high with RxValid only when the word is the first of the frame.
REQ-013 FrameStart  out  1  one-CLK pulse on the synchronized _CS falling edge.
REQ-014 FrameEnd  out  1  one-CLK pulse on the synchronized _CS rising edge.
REQ-015 Busy  out  1  high while the state is ACTIVE.

Function
REQ-016 SHALL pass SCK, MOSI and _CS through SYNC_STAGES flops each, then edge-detect SCK and _CS with one further register.
REQ-017 SHALL require CLK >= 4x SCK; behaviour is undefined below that ratio.
REQ-018 SHALL implement states IDLE, ARMED, ACTIVE: IDLE->ARMED when synchronized _CS=1; ARMED->ACTIVE on the _CS falling edge; ACTIVE->ARMED on the _CS rising edge.
REQ-019 SHALL, on the ARMED->ACTIVE transition: pulse FrameStart, clear the bit counter, set the first-word flag, and load TxByte into the transmit shifter.
REQ-020 SHALL, in ACTIVE, shift synchronized MOSI in on each SCK rising edge, MSB first.
REQ-021 SHALL, on the BITS-th rising edge: update RxByte, pulse RxValid, drive FirstByte=first-word flag, clear the flag, and wrap the counter to 0.
REQ-022 SHALL assert RxValid exactly SYNC_STAGES+2 CLK cycles after the raw SCK rising edge that completes a word.
REQ-023 SHALL, in ACTIVE, advance the transmit shifter on each SCK falling edge, and reload it from TxByte on the falling edge that follows a completed word.
REQ-024 SHALL ignore SCK edges in IDLE and ARMED.
REQ-025 SHALL, on a _CS rising edge mid-word, discard the partial word (no RxValid, RxByte unchanged) and pulse FrameEnd.
REQ-026 SHALL, when the completing SCK edge and the _CS rising edge are detected in the same cycle, pulse RxValid and FrameEnd together in that cycle.
REQ-027 SHALL drive MISO=0 whenever the state is not ACTIVE.

Reset
REQ-028 SHALL, while RST=1, force: state=IDLE; RxByte, RxValid, FirstByte, FrameStart, FrameEnd, Busy and MISO to 0; counter and shifters to 0.
REQ-029 SHALL reset the synchronizers to idle levels: SCK=0, MOSI=0, _CS=1.
REQ-030 SHALL, after reset is released mid-frame (_CS held low), start no frame until _CS has been sampled high, then low; no pulses are generated for the aborted frame.

Configuration
REQ-031 SHALL use macro SPI_MISO_EN: when defined, the transmit shifter and MISO drive per REQ-019/023/027 are present.
REQ-032 SHALL, when SPI_MISO_EN is undefined, omit the transmit shifter, tie MISO to 0, and leave TxByte unused.

Structure
REQ-033 SHALL place the state encoding (IDLE/ARMED/ACTIVE) and the default word length constant in shared package spi_pkg.
REQ-034 SHALL instantiate sub-module spi_sync (parameterized N-stage synchronizer with reset value input) once per SPI pin.

Verification
REQ-035 Single frame of 0xA5 at CLK/8 -> one RxValid with RxByte=0xA5 and FirstByte=1; FrameStart and FrameEnd each pulse once.
REQ-036 Frame 0x3C,0x81,0xFF -> three RxValid pulses in that order; FirstByte=1 on 0x3C only; RxValid occurs SYNC_STAGES+2 cycles after each 8th SCK rise.
REQ-037 With SPI_MISO_EN defined and TxByte=0xC3, then 0x5A -> MISO shifts out 0xC3, then 0x5A, MSB first; MISO=0 outside the frame.
REQ-038 _CS rises after 5 bits of 0xF0 -> no RxValid, RxByte keeps its prior value, FrameEnd pulses once; the next frame of 0x12 is received with FirstByte=1.
REQ-039 RST=1 asserted mid-word with _CS low, then released -> all outputs 0; SCK toggling is ignored until _CS goes high and then low again.
REQ-040 SCK toggling with _CS high -> no RxValid, FrameStart or Busy activity.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte shifter: FSM state encoding and
// the default SPI word length.
package spi_pkg;

    // Frame-level state of the slave
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2
    } spi_state_t;

    // Default SPI word length in bits
    localparam int SPI_DEFAULT_BITS = 8;

endpackage

// File: rtl/spi_sync.sv
// N-stage synchronizer for one asynchronous SPI pin. The reset value is an
// input so each pin can power up at its own idle level.
module spi_sync #(
    parameter int N = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic RstVal,
    input  logic D,
    output logic Q
);

    logic [N-1:0] stages;

    // Shift the raw pin through N flops; reset loads the pin's idle level
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stages <= {N{RstVal}};
        end else begin
            stages <= {stages[N-2:0], D};
        end
    end

    assign Q = stages[N-1];

endmodule

// File: rtl/spi_byte_shifter.sv
// SPI mode-0 slave byte shifter running entirely in the CLK domain.
// Raw SCK/MOSI/_CS are synchronized, edge-detected and fed to an
// IDLE/ARMED/ACTIVE frame FSM that assembles received words.
// Optional MISO transmit path is built only when SPI_MISO_EN is defined;
// otherwise MISO is tied low and TxByte is unused.
module spi_byte_shifter
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BITS        = SPI_DEFAULT_BITS
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            SCK,
    input  logic            MOSI,
    input  logic            _CS,
    output logic            MISO,
    input  logic [BITS-1:0] TxByte,
    output logic [BITS-1:0] RxByte,
    output logic            RxValid,
    output logic            FirstByte,
    output logic            FrameStart,
    output logic            FrameEnd,
    output logic            Busy
);

    localparam int            CW        = $clog2(BITS);
    localparam logic [CW-1:0] LAST_BIT  = CW'(BITS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [2:0]    FILL_DONE = 3'(SYNC_STAGES + 1);

    logic sck_s, mosi_s, cs_s;

    spi_sync #(.N(SYNC_STAGES)) u_sync_sck (
        .CLK(CLK), .RST(RST), .RstVal(1'b0), .D(SCK), .Q(sck_s)
    );
    spi_sync #(.N(SYNC_STAGES)) u_sync_mosi (
        .CLK(CLK), .RST(RST), .RstVal(1'b0), .D(MOSI), .Q(mosi_s)
    );
    spi_sync #(.N(SYNC_STAGES)) u_sync_cs (
        .CLK(CLK), .RST(RST), .RstVal(1'b1), .D(_CS), .Q(cs_s)
    );

    logic       sck_d, cs_d, mosi_d;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;
    logic [2:0] fill_cnt;
    logic       fill_done;

    // Registered edge pulses; MOSI is delayed once more so it lines up with
    // the SCK rise pulse. fill_cnt marks when the synchronizers hold real
    // pin samples rather than their reset levels.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sck_d    <= 1'b0;
            cs_d     <= 1'b1;
            mosi_d   <= 1'b0;
            sck_rise <= 1'b0;
            sck_fall <= 1'b0;
            cs_rise  <= 1'b0;
            cs_fall  <= 1'b0;
            fill_cnt <= 3'd0;
        end else begin
            sck_d    <= sck_s;
            cs_d     <= cs_s;
            mosi_d   <= mosi_s;
            sck_rise <= sck_s & ~sck_d;
            sck_fall <= ~sck_s & sck_d;
            cs_rise  <= cs_s & ~cs_d;
            cs_fall  <= ~cs_s & cs_d;
            if (fill_cnt != FILL_DONE) begin
                fill_cnt <= fill_cnt + 3'd1;
            end
        end
    end

    assign fill_done = (fill_cnt == FILL_DONE);

    spi_state_t      state;
    logic [CW-1:0]   bit_cnt;
    logic [BITS-1:0] rx_sh;
    logic [BITS-1:0] rx_next;
    logic            first_word;
    logic            word_done;

    assign rx_next   = {rx_sh[BITS-2:0], mosi_d};
    assign word_done = sck_rise && (bit_cnt == LAST_BIT);

    // Frame FSM: a frame only starts from ARMED, which requires _CS to have
    // been genuinely sampled high, so a frame cut by reset is never resumed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_sh      <= '0;
            first_word <= 1'b0;
            RxByte     <= '0;
            RxValid    <= 1'b0;
            FirstByte  <= 1'b0;
            FrameStart <= 1'b0;
            FrameEnd   <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            RxValid    <= 1'b0;
            FirstByte  <= 1'b0;
            FrameStart <= 1'b0;
            FrameEnd   <= 1'b0;
            case (state)
                IDLE: begin
                    if (fill_done && cs_s) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (cs_fall) begin
                        state      <= ACTIVE;
                        Busy       <= 1'b1;
                        FrameStart <= 1'b1;
                        bit_cnt    <= '0;
                        first_word <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (sck_rise) begin
                        rx_sh <= rx_next;
                        if (word_done) begin
                            RxByte     <= rx_next;
                            RxValid    <= 1'b1;
                            FirstByte  <= first_word;
                            first_word <= 1'b0;
                            bit_cnt    <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_ONE;
                        end
                    end
                    // A partial word is simply abandoned; bit_cnt is cleared
                    // when the next frame starts.
                    if (cs_rise) begin
                        state    <= ARMED;
                        Busy     <= 1'b0;
                        FrameEnd <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_MISO_EN
    logic [BITS-1:0] tx_sh;
    logic            reload_pend;

    // Transmit shifter: loaded at frame start, shifted on SCK falls, and
    // reloaded on the first fall after each completed word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_sh       <= '0;
            reload_pend <= 1'b0;
        end else if (state == ARMED && cs_fall) begin
            tx_sh       <= TxByte;
            reload_pend <= 1'b0;
        end else if (state == ACTIVE) begin
            if (word_done) begin
                reload_pend <= 1'b1;
            end
            if (sck_fall) begin
                if (reload_pend) begin
                    tx_sh       <= TxByte;
                    reload_pend <= 1'b0;
                end else begin
                    tx_sh <= {tx_sh[BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign MISO = (state == ACTIVE) ? tx_sh[BITS-1] : 1'b0;
`else
    logic unused_tx;

    assign unused_tx = ^{TxByte, sck_fall};
    assign MISO      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Directed bench for spi_byte_shifter: reset, single and multi-word frames,
// MISO shifting, mid-word abort, reset mid-frame and SCK with _CS high.
module tb_spi_byte_shifter;

    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       cs_n = 1'b1;
    logic       miso;
    logic [7:0] tx_byte = 8'h00;
    logic [7:0] rx_byte;
    logic       rx_valid, first_byte, frame_start, frame_end, busy;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int rise_cyc = 0;
    int fs_cnt = 0;
    int fe_cnt = 0;
    int busy_cnt = 0;
    logic [7:0] rx_q[$];
    logic       first_q[$];
    int         lat_q[$];

    spi_byte_shifter #(.SYNC_STAGES(SYNC_STAGES), .BITS(8)) dut (
        .CLK(clk), .RST(rst), .SCK(sck), .MOSI(mosi), ._CS(cs_n),
        .MISO(miso), .TxByte(tx_byte), .RxByte(rx_byte), .RxValid(rx_valid),
        .FirstByte(first_byte), .FrameStart(frame_start),
        .FrameEnd(frame_end), .Busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Event log sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_q.push_back(rx_byte);
            first_q.push_back(first_byte);
            lat_q.push_back(cyc - rise_cyc);
        end
        if (frame_start) fs_cnt++;
        if (frame_end) fe_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic spi_bits(input logic [7:0] b, input int nb, input int h,
                            output logic [7:0] mw);
        mw = 8'h00;
        for (int i = 7; i > 7 - nb; i--) begin
            mosi = b[i];
            repeat (h) @(negedge clk);
            mw = {mw[6:0], miso};
            sck = 1'b1;
            rise_cyc = cyc;
            repeat (h) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic cs_low(input int h);
        cs_n = 1'b0;
        repeat (h) @(negedge clk);
    endtask

    task automatic cs_high(input int h);
        repeat (h) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rxbyte got %h want 00", rx_byte); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rxvalid got %b want 0", rx_valid); end
        checks++; if ({first_byte, frame_start, frame_end} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {first_byte, frame_start, frame_end}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", miso); end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (busy_cnt !== 0 || fs_cnt !== 0) begin errors++; $display("FAIL reset_idle busy_cnt %0d fs_cnt %0d want 0 0", busy_cnt, fs_cnt); end
    endtask

    task automatic test_single;
        int base, fs0, fe0, b0;
        logic [7:0] mw;
        base = rx_q.size(); fs0 = fs_cnt; fe0 = fe_cnt; b0 = busy_cnt;
        cs_low(4);
        spi_bits(8'hA5, 8, 4, mw);
        cs_high(4);
        checks++; if (rx_q.size() - base !== 1) begin errors++; $display("FAIL single_count got %0d want 1", rx_q.size() - base); end
        if (rx_q.size() - base == 1) begin
            checks++; if (rx_q[base] !== 8'hA5) begin errors++; $display("FAIL single_word got %h want a5", rx_q[base]); end
            checks++; if (first_q[base] !== 1'b1) begin errors++; $display("FAIL single_first got %b want 1", first_q[base]); end
        end
        checks++; if (fs_cnt - fs0 !== 1) begin errors++; $display("FAIL single_framestart got %0d want 1", fs_cnt - fs0); end
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL single_frameend got %0d want 1", fe_cnt - fe0); end
        checks++; if (busy_cnt == b0) begin errors++; $display("FAIL single_busy got 0 busy cycles want >0"); end
        checks++; if (rx_byte !== 8'hA5) begin errors++; $display("FAIL single_hold got %h want a5", rx_byte); end
    endtask

    task automatic test_back_to_back;
        int base;
        logic [7:0] mw;
        logic [7:0] exp_w[3];
        exp_w[0] = 8'h3C; exp_w[1] = 8'h81; exp_w[2] = 8'hFF;
        base = rx_q.size();
        cs_low(4);
        for (int k = 0; k < 3; k++) spi_bits(exp_w[k], 8, 4, mw);
        cs_high(4);
        checks++; if (rx_q.size() - base !== 3) begin errors++; $display("FAIL multi_count got %0d want 3", rx_q.size() - base); end
        if (rx_q.size() - base == 3) begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (rx_q[base+k] !== exp_w[k]) begin errors++; $display("FAIL multi_word%0d got %h want %h", k, rx_q[base+k], exp_w[k]); end
                checks++; if (first_q[base+k] !== (k == 0)) begin errors++; $display("FAIL multi_first%0d got %b want %b", k, first_q[base+k], k == 0); end
                checks++; if (lat_q[base+k] !== SYNC_STAGES + 2) begin errors++; $display("FAIL multi_latency%0d got %0d want %0d", k, lat_q[base+k], SYNC_STAGES + 2); end
            end
        end
    endtask

    task automatic test_miso;
        logic [7:0] mw0, mw1, exp0, exp1;
`ifdef SPI_MISO_EN
        exp0 = 8'hC3; exp1 = 8'h5A;
`else
        exp0 = 8'h00; exp1 = 8'h00;
`endif
        tx_byte = 8'hC3;
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL miso_preframe got %b want 0", miso); end
        cs_low(8);
        spi_bits(8'h66, 8, 8, mw0);
        tx_byte = 8'h5A;
        spi_bits(8'h99, 8, 8, mw1);
        cs_high(8);
        checks++; if (mw0 !== exp0) begin errors++; $display("FAIL miso_word0 got %h want %h", mw0, exp0); end
        checks++; if (mw1 !== exp1) begin errors++; $display("FAIL miso_word1 got %h want %h", mw1, exp1); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL miso_postframe got %b want 0", miso); end
        checks++; if (rx_byte !== 8'h99) begin errors++; $display("FAIL miso_rx got %h want 99", rx_byte); end
    endtask

    task automatic test_abort;
        int base, fe0;
        logic [7:0] mw;
        base = rx_q.size(); fe0 = fe_cnt;
        cs_low(4);
        spi_bits(8'hF0, 5, 4, mw);
        cs_high(4);
        checks++; if (rx_q.size() !== base) begin errors++; $display("FAIL abort_norxvalid got %0d words want 0", rx_q.size() - base); end
        checks++; if (rx_byte !== 8'h99) begin errors++; $display("FAIL abort_rxhold got %h want 99", rx_byte); end
        checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL abort_frameend got %0d want 1", fe_cnt - fe0); end
        base = rx_q.size();
        cs_low(4);
        spi_bits(8'h12, 8, 4, mw);
        cs_high(4);
        checks++; if (rx_q.size() - base !== 1) begin errors++; $display("FAIL abort_next_count got %0d want 1", rx_q.size() - base); end
        if (rx_q.size() - base == 1) begin
            checks++; if (rx_q[base] !== 8'h12 || first_q[base] !== 1'b1) begin errors++; $display("FAIL abort_next_word got %h/%b want 12/1", rx_q[base], first_q[base]); end
        end
    endtask

    task automatic test_reset_midframe;
        int base, fs0, fe0, b0;
        logic [7:0] mw;
        cs_low(4);
        spi_bits(8'hE0, 3, 4, mw);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({rx_valid, first_byte, frame_start, frame_end, busy, miso} !== 6'b0 || rx_byte !== 8'h00) begin errors++; $display("FAIL midrst_outputs got %b/%h want 000000/00", {rx_valid, first_byte, frame_start, frame_end, busy, miso}, rx_byte); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = rx_q.size(); fs0 = fs_cnt; fe0 = fe_cnt; b0 = busy_cnt;
        repeat (4) @(negedge clk);
        spi_bits(8'hFF, 8, 4, mw);
        cs_high(4);
        checks++; if (rx_q.size() !== base || fs_cnt !== fs0 || fe_cnt !== fe0 || busy_cnt !== b0) begin errors++; $display("FAIL midrst_ignored words %0d fs %0d fe %0d busy %0d want 0 0 0 0", rx_q.size() - base, fs_cnt - fs0, fe_cnt - fe0, busy_cnt - b0); end
        checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL midrst_rxbyte got %h want 00", rx_byte); end
        cs_low(4);
        spi_bits(8'h5A, 8, 4, mw);
        cs_high(4);
        checks++; if (rx_q.size() - base !== 1 || fs_cnt - fs0 !== 1) begin errors++; $display("FAIL midrst_recover words %0d fs %0d want 1 1", rx_q.size() - base, fs_cnt - fs0); end
        if (rx_q.size() - base == 1) begin
            checks++; if (rx_q[base] !== 8'h5A || first_q[base] !== 1'b1) begin errors++; $display("FAIL midrst_word got %h/%b want 5a/1", rx_q[base], first_q[base]); end
        end
    endtask

    task automatic test_cs_high_sck;
        int base, fs0, b0;
        logic [7:0] mw;
        base = rx_q.size(); fs0 = fs_cnt; b0 = busy_cnt;
        spi_bits(8'hA5, 8, 4, mw);
        repeat (10) @(negedge clk);
        checks++; if (rx_q.size() !== base || fs_cnt !== fs0 || busy_cnt !== b0) begin errors++; $display("FAIL cshigh_activity words %0d fs %0d busy %0d want 0 0 0", rx_q.size() - base, fs_cnt - fs0, busy_cnt - b0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_miso();
        test_abort();
        test_reset_midframe();
        test_cs_high_sck();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
